lcd_reader: RTL and testbench

- Read-side counterpart to the HD44780 4-bit write path (lcd_init) that drives LCD_D/LCD_E.
- Performs one 8-bit read cycle from the LCD controller as two 4-bit nibbles, high nibble first.
- RS=0 reads busy flag plus address counter; RS=1 reads DDRAM/CGRAM data.
- Sits beside the writer on the shared LCD bus. The top level tristates the writer's data drivers while LCD_DB_RELEASE=1.

---
 rtl/lcd_reader_if.sv | 11 +
 rtl/lcd_reader.sv | 122 ++++++++++++
 tb/tb_lcd_reader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_reader_if.sv
// HD44780 4-bit read-side pin bundle: control strobes out to the pad, D7..D4 back in.
interface lcd_reader_if;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic       LCD_DB_RELEASE;
    logic [3:0] LCD_DB_IN;

    modport master (output LCD_RS, LCD_RW, LCD_E, LCD_DB_RELEASE, input LCD_DB_IN);
    modport slave  (input LCD_RS, LCD_RW, LCD_E, LCD_DB_RELEASE, output LCD_DB_IN);
endinterface

// File: rtl/lcd_reader.sv
// HD44780 4-bit read cycle (high nibble first), busy/address or data register.
// Optional busy-flag polling loop when LCD_RD_POLL_EN is defined.
module lcd_reader #(
    parameter int T_SETUP  = 2,
    parameter int T_EH     = 12,
    parameter int T_EL     = 13,
    parameter int POLL_MAX = 255
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         req,
    input  logic         rs_sel,
    lcd_reader_if.master lcd,
    output logic         busy,
    output logic         done,
    output logic [7:0]   rd_data,
    output logic         bf,
    output logic         timeout
);
    localparam int T_MAX = (T_SETUP > T_EH) ? ((T_SETUP > T_EL) ? T_SETUP : T_EL)
                                            : ((T_EH > T_EL) ? T_EH : T_EL);
    localparam int CW = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HI1, LO1, HI2, LO2, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, phase_last;
    logic          phase_end;
    logic          rs_q;
    logic          poll_again;

    always_comb begin
        phase_last = '0;
        case (state)
            SETUP:    phase_last = CW'(T_SETUP - 1);
            HI1, HI2: phase_last = CW'(T_EH - 1);
            LO1, LO2: phase_last = CW'(T_EL - 1);
            default:  phase_last = '0;
        endcase
    end

    assign phase_end = (cnt == phase_last);

`ifdef LCD_RD_POLL_EN
    localparam int PW = $clog2(POLL_MAX + 1);
    logic [PW-1:0] poll_cnt;

    // poll_cnt counts completed reads before the current one
    assign poll_again = !rs_q && rd_data[7] && (poll_cnt < PW'(POLL_MAX - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            poll_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == IDLE && req)
                poll_cnt <= '0;
            else if (state == LO2 && phase_end)
                poll_cnt <= poll_cnt + 1'b1;
            timeout <= (state == LO2) && (state_nxt == DONE) && !rs_q && rd_data[7];
        end
    end
`else
    assign poll_again = 1'b0;
    // POLL_MAX only matters in poll builds; an illegal 0 would show up here
    assign timeout    = (POLL_MAX < 1);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = SETUP;
            SETUP:   if (phase_end) state_nxt = HI1;
            HI1:     if (phase_end) state_nxt = LO1;
            LO1:     if (phase_end) state_nxt = HI2;
            HI2:     if (phase_end) state_nxt = LO2;
            LO2:     if (phase_end) state_nxt = poll_again ? HI1 : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state              <= IDLE;
            cnt                <= '0;
            rs_q               <= 1'b0;
            lcd.LCD_RS         <= 1'b0;
            lcd.LCD_RW         <= 1'b0;
            lcd.LCD_E          <= 1'b0;
            lcd.LCD_DB_RELEASE <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            rd_data            <= 8'h00;
            bf                 <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
            lcd.LCD_E <= (state_nxt == HI1) || (state_nxt == HI2);
            busy      <= (state_nxt != IDLE);
            done      <= (state_nxt == DONE);

            if (state == IDLE && req) begin
                rs_q               <= rs_sel;
                lcd.LCD_RS         <= rs_sel;
                lcd.LCD_RW         <= 1'b1;
                lcd.LCD_DB_RELEASE <= 1'b1;
            end

            // nibbles are sampled on the edge that drops E
            if (state == HI1 && state_nxt == LO1) rd_data[7:4] <= lcd.LCD_DB_IN;
            if (state == HI2 && state_nxt == LO2) rd_data[3:0] <= lcd.LCD_DB_IN;

            if (state == LO2 && state_nxt == DONE) begin
                lcd.LCD_RS         <= 1'b0;
                lcd.LCD_RW         <= 1'b0;
                lcd.LCD_DB_RELEASE <= 1'b0;
                if (!rs_q) bf <= rd_data[7];
            end
        end
    end
endmodule

// File: tb/tb_lcd_reader.sv
// Directed self-checking bench for lcd_reader (default timing; poll cases with LCD_RD_POLL_EN).
module tb_lcd_reader;
`ifdef LCD_RD_POLL_EN
    localparam int POLL_MAX_TB = 4;
`else
    localparam int POLL_MAX_TB = 255;
`endif

    logic       CLK, RST_N, req, rs_sel;
    logic       busy, done, bf, timeout;
    logic [7:0] rd_data;
    int         checks, errors;

    lcd_reader_if lcd ();

    lcd_reader #(.T_SETUP(2), .T_EH(12), .T_EL(13), .POLL_MAX(POLL_MAX_TB)) dut (
        .CLK(CLK), .RST_N(RST_N), .req(req), .rs_sel(rs_sel), .lcd(lcd.master),
        .busy(busy), .done(done), .rd_data(rd_data), .bf(bf), .timeout(timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One read, req sampled at edge k; optional extra req pulse sampled at edge k+dup_at.
    task automatic xfer(input logic rs, input logic [3:0] hi, input logic [3:0] lo,
                        input int dup_at, input logic bf_exp);
        logic [7:0] prev;
        logic       exp_e;
        int         ndone;
        prev = rd_data;
        ndone = 0;
        chk("idle_busy", 32'(busy), 0);
        rs_sel = rs; req = 1'b1; lcd.LCD_DB_IN = hi;
        tick();
        req = 1'b0; rs_sel = ~rs;
        chk("acc_rw", 32'(lcd.LCD_RW), 1);
        chk("acc_rs", 32'(lcd.LCD_RS), 32'(rs));
        chk("acc_rel", 32'(lcd.LCD_DB_RELEASE), 1);
        chk("acc_busy", 32'(busy), 1);
        chk("acc_e", 32'(lcd.LCD_E), 0);
        for (int i = 1; i <= 53; i++) begin
            req = (i == dup_at);
            if (i == 15) lcd.LCD_DB_IN = lo;
            tick();
            exp_e = (i >= 2 && i < 14) || (i >= 27 && i < 39);
            chk($sformatf("e_k%0d", i), 32'(lcd.LCD_E), 32'(exp_e));
            if (exp_e) begin
                chk("e_rs", 32'(lcd.LCD_RS), 32'(rs));
                chk("e_rw", 32'(lcd.LCD_RW), 1);
            end
            if (done) ndone++;
            if (i == 13) chk("rd_hold", 32'(rd_data), 32'(prev));
            if (i == 20) chk("rd_hi", 32'(rd_data), 32'({hi, prev[3:0]}));
            if (i == 51) begin
                chk("rel_k51", 32'(lcd.LCD_DB_RELEASE), 1);
                chk("done_k51", 32'(done), 0);
            end
            if (i == 52) begin
                chk("done_k52", 32'(done), 1);
                chk("rd_data", 32'(rd_data), 32'({hi, lo}));
                chk("done_rw", 32'(lcd.LCD_RW), 0);
                chk("done_rs", 32'(lcd.LCD_RS), 0);
                chk("done_rel", 32'(lcd.LCD_DB_RELEASE), 0);
                chk("done_busy", 32'(busy), 1);
                chk("done_bf", 32'(bf), 32'(bf_exp));
                chk("done_to", 32'(timeout), 0);
            end
            if (i == 53) begin
                chk("k53_busy", 32'(busy), 0);
                chk("k53_done", 32'(done), 0);
            end
        end
        req = 1'b0;
        tick();
        tick();
        chk("no_queue", 32'(busy), 0);
        chk("ndone", 32'(ndone), 1);
    endtask

    // E-rise driven pin model: nibble for pulse n comes from nib(n); runs until done or budget.
    task automatic run_model(input logic rs, input int bf_reads, input logic hold_req,
                             input int want_done, output int rises, output int ndone,
                             output int done_cyc[2], output logic [7:0] done_rd[2],
                             output logic done_to);
        logic pe;
        int   cyc;
        rises = 0; ndone = 0; pe = 1'b0; cyc = 0; done_to = 1'b0;
        done_cyc[0] = 0; done_cyc[1] = 0; done_rd[0] = 8'h00; done_rd[1] = 8'h00;
        rs_sel = rs; req = 1'b1;
        while (ndone < want_done && cyc < 2000) begin
            tick();
            cyc++;
            if (!hold_req) req = 1'b0;
            if (lcd.LCD_E && !pe) begin
                if (bf_reads < 0)
                    lcd.LCD_DB_IN = (rises == 0) ? 4'h3 : (rises == 1) ? 4'hC :
                                    (rises == 2) ? 4'hC : 4'h3;
                else if (rises % 2 == 0)
                    lcd.LCD_DB_IN = (rises / 2 < bf_reads) ? 4'h8 : 4'h0;
                else
                    lcd.LCD_DB_IN = 4'h3;
                rises++;
            end
            pe = lcd.LCD_E;
            if (done) begin
                done_cyc[ndone] = cyc;
                done_rd[ndone] = rd_data;
                done_to = timeout;
                ndone++;
                if (ndone == want_done) req = 1'b0;
            end
        end
        req = 1'b0;
        repeat (4) tick();
        chk("model_idle", 32'(busy), 0);
    endtask

    initial begin
        int         rises, ndone;
        int         dcyc[2];
        logic [7:0] drd[2];
        logic       dto;
        checks = 0; errors = 0;
        req = 1'b0; rs_sel = 1'b0; lcd.LCD_DB_IN = 4'h0;
        RST_N = 1'b1;
        #1 RST_N = 1'b0;
        #2;
        chk("rst_e", 32'(lcd.LCD_E), 0);
        chk("rst_rw", 32'(lcd.LCD_RW), 0);
        chk("rst_rs", 32'(lcd.LCD_RS), 0);
        chk("rst_rel", 32'(lcd.LCD_DB_RELEASE), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rd", 32'(rd_data), 0);
        chk("rst_bf", 32'(bf), 0);
        chk("rst_to", 32'(timeout), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        xfer(1'b0, 4'h8, 4'hC, 0, 1'b1);   // busy read, BF=1
        xfer(1'b1, 4'hA, 4'h5, 20, 1'b1);  // data read, req mid-flight ignored, bf kept
        xfer(1'b1, 4'h6, 4'h9, 53, 1'b1);  // req during DONE ignored

        // reset while E is high in the second nibble
        rs_sel = 1'b1; req = 1'b1; lcd.LCD_DB_IN = 4'hF;
        tick();
        req = 1'b0;
        repeat (30) tick();
        chk("mid_e_high", 32'(lcd.LCD_E), 1);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_e", 32'(lcd.LCD_E), 0);
        chk("mid_rw", 32'(lcd.LCD_RW), 0);
        chk("mid_rel", 32'(lcd.LCD_DB_RELEASE), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_rd", 32'(rd_data), 0);
        chk("mid_bf", 32'(bf), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        xfer(1'b0, 4'h2, 4'h7, 0, 1'b0);   // busy read with BF=0 after reset

        // back-to-back with req held high
        run_model(1'b1, -1, 1'b1, 2, rises, ndone, dcyc, drd, dto);
        chk("b2b_ndone", 32'(ndone), 2);
        chk("b2b_gap", 32'(dcyc[1] - dcyc[0]), 54);
        chk("b2b_rd0", 32'(drd[0]), 32'h3C);
        chk("b2b_rd1", 32'(drd[1]), 32'hC3);
        chk("b2b_bf", 32'(bf), 0);

`ifdef LCD_RD_POLL_EN
        run_model(1'b0, 3, 1'b0, 1, rises, ndone, dcyc, drd, dto);
        chk("poll_rises", 32'(rises), 8);
        chk("poll_ndone", 32'(ndone), 1);
        chk("poll_to", 32'(dto), 0);
        chk("poll_rd", 32'(drd[0]), 32'h03);
        chk("poll_bf", 32'(bf), 0);
        run_model(1'b0, 99, 1'b0, 1, rises, ndone, dcyc, drd, dto);
        chk("stuck_rises", 32'(rises), 8);
        chk("stuck_ndone", 32'(ndone), 1);
        chk("stuck_to", 32'(dto), 1);
        chk("stuck_rd", 32'(drd[0]), 32'h83);
        chk("stuck_bf", 32'(bf), 1);
        chk("stuck_to_clr", 32'(timeout), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
